// File: rtl/add_pipe.sv
// Pipelined adder/subtractor that resolves one SEG-bit segment per stage with the carry
// registered between stages. It has a valid/ready handshake, and a stall freezes the whole pipe.
module add_pipe #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = WIDTH / SEG;
   localparam int LAST   = STAGES - 1;

   logic             vld_reg [STAGES];
   logic             cy_reg  [STAGES];
   logic [WIDTH-1:0] a_reg   [STAGES];
   logic [WIDTH-1:0] b_reg   [STAGES];
   logic [WIDTH-1:0] sum_reg [STAGES];
   logic             adv;

   // The pipe moves as a single unit: either every stage shifts or every stage holds.
   assign adv      = !vld_reg[LAST] || out_ready;
   assign in_ready = adv || !rst_n;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         logic             v_in;
         logic             c_in;
         logic [WIDTH-1:0] a_in;
         logic [WIDTH-1:0] b_in;
         logic [WIDTH-1:0] s_in;
         logic [WIDTH-1:0] sum_next;
         logic [SEG:0]     seg_sum;

         if (gi == 0) begin : g_entry
            // Subtraction is A + ~B + !cin, so borrow-in becomes an inverted carry-in.
            assign v_in = in_valid;
            assign a_in = in1;
            assign b_in = sub ? ~in2 : in2;
            assign c_in = cin ^ sub;
            assign s_in = '0;
         end else begin : g_link
            assign v_in = vld_reg[gi-1];
            assign a_in = a_reg[gi-1];
            assign b_in = b_reg[gi-1];
            assign c_in = cy_reg[gi-1];
            assign s_in = sum_reg[gi-1];
         end

         assign seg_sum = {1'b0, a_in[gi*SEG +: SEG]} + {1'b0, b_in[gi*SEG +: SEG]}
                        + {{SEG{1'b0}}, c_in};

         always_comb begin
            sum_next                 = s_in;
            sum_next[gi*SEG +: SEG]  = seg_sum[SEG-1:0];
         end

         // Data loads only with a valid entry, so bubbles leave the last result on the outputs.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               vld_reg[gi] <= 1'b0;
               cy_reg[gi]  <= 1'b0;
               a_reg[gi]   <= '0;
               b_reg[gi]   <= '0;
               sum_reg[gi] <= '0;
            end else if (adv) begin
               vld_reg[gi] <= v_in;
               if (v_in) begin
                  cy_reg[gi]  <= seg_sum[SEG];
                  a_reg[gi]   <= a_in;
                  b_reg[gi]   <= b_in;
                  sum_reg[gi] <= sum_next;
               end
            end
         end
      end
   endgenerate

   assign out_valid = vld_reg[LAST];
   assign out       = sum_reg[LAST];
   assign cout      = cy_reg[LAST];
   assign ovf       = (a_reg[LAST][WIDTH-1] == b_reg[LAST][WIDTH-1])
                   && (sum_reg[LAST][WIDTH-1] != a_reg[LAST][WIDTH-1]);

endmodule

// File: tb/tb_add_pipe.sv
// Bench for add_pipe: three instances (16/4, 32/8, 8/8) under directed and random stimulus,
// checked every cycle against an arithmetic reference model.
module tb_add_pipe;
   localparam int N = 3;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   in_valid, cin, sub, out_ready;
   wire  [N-1:0]   in_ready, out_valid, cout, ovf;
   logic [31:0]    in1 [N];
   logic [31:0]    in2 [N];
   wire  [15:0]    out0;
   wire  [31:0]    out1;
   wire  [7:0]     out2;
   logic [31:0]    outv [N];

   int             checks = 0;
   int             failures = 0;
   int             cyc = 0;
   int             acc_cnt [N];
   logic [33:0]    exp_q [N][$];
   int             acc_q [N][$];
   logic [33:0]    log_val [N][$];
   int             log_lat [N][$];
   logic           held [N];
   logic [33:0]    last [N];
   logic [33:0]    mon_cur;
   int             mon_lat;

   always #5 clk = ~clk;

   add_pipe #(.WIDTH(16), .SEG(4)) u_d16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in1(in1[0][15:0]), .in2(in2[0][15:0]), .cin(cin[0]), .sub(sub[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out(out0), .cout(cout[0]), .ovf(ovf[0]));
   add_pipe #(.WIDTH(32), .SEG(8)) u_d32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in1(in1[1]), .in2(in2[1]), .cin(cin[1]), .sub(sub[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out(out1), .cout(cout[1]), .ovf(ovf[1]));
   add_pipe #(.WIDTH(8), .SEG(8)) u_d8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in1(in1[2][7:0]), .in2(in2[2][7:0]), .cin(cin[2]), .sub(sub[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out(out2), .cout(cout[2]), .ovf(ovf[2]));

   always_comb begin
      outv[0] = {16'h0, out0};
      outv[1] = out1;
      outv[2] = {24'h0, out2};
   end

   function automatic int wof(int i);
      case (i)
         0:       return 16;
         1:       return 32;
         default: return 8;
      endcase
   endfunction

   function automatic int sof(int i);
      return (i == 2) ? 1 : 4;
   endfunction

   function automatic logic [31:0] mk(int i);
      logic [63:0] m;
      m = (64'd1 << wof(i)) - 64'd1;
      return m[31:0];
   endfunction

   // Reference: plain integer arithmetic; returns {ovf, cout, out}.
   function automatic logic [33:0] ref_calc(int w, logic [31:0] a, logic [31:0] b, logic c, logic s);
      longint m, full, sa, sb, sr;
      logic [63:0] o;
      logic co, ov;
      m = longint'(1) << w;
      if (!s) full = longint'(a) + longint'(b) + longint'(c);
      else    full = longint'(a) - longint'(b) - longint'(c) + m;
      co = (full >= m);
      o  = 64'(full % m);
      sa = (longint'(a) >= m / 2) ? longint'(a) - m : longint'(a);
      sb = (longint'(b) >= m / 2) ? longint'(b) - m : longint'(b);
      sr = s ? (sa - sb - longint'(c)) : (sa + sb + longint'(c));
      ov = (sr < -(m / 2)) || (sr >= m / 2);
      return {ov, co, o[31:0]};
   endfunction

   // Cycle monitor: handshake rule, stability, retention, ordering and values.
   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < N; i++) begin
         checks++;
         if (in_ready[i] !== (!out_valid[i] || out_ready[i] || !rst_n)) begin
            failures++;
            $display("FAIL in_ready inst%0d got=%b want=%b", i, in_ready[i],
                     (!out_valid[i] || out_ready[i] || !rst_n));
         end
         if (!rst_n) begin
            exp_q[i].delete();
            acc_q[i].delete();
            held[i] = 1'b0;
            last[i] = '0;
            continue;
         end
         mon_cur = {ovf[i], cout[i], outv[i]};
         if (!out_valid[i]) begin
            checks++;
            if (mon_cur !== last[i]) begin
               failures++;
               $display("FAIL retain inst%0d got=%h want=%h", i, mon_cur, last[i]);
            end
         end else begin
            if (held[i]) begin
               checks++;
               if (mon_cur !== last[i]) begin
                  failures++;
                  $display("FAIL stable inst%0d got=%h want=%h", i, mon_cur, last[i]);
               end
            end else if (exp_q[i].size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected inst%0d got=%h want=none", i, mon_cur);
            end else begin
               mon_lat = cyc - acc_q[i][0];
               checks++;
               if (mon_cur !== exp_q[i][0]) begin
                  failures++;
                  $display("FAIL value inst%0d got=%h want=%h", i, mon_cur, exp_q[i][0]);
               end
               checks++;
               if (mon_lat < sof(i)) begin
                  failures++;
                  $display("FAIL min_latency inst%0d got=%0d want>=%0d", i, mon_lat, sof(i));
               end
               log_val[i].push_back(mon_cur);
               log_lat[i].push_back(mon_lat);
            end
            last[i] = mon_cur;
            if (out_ready[i] && exp_q[i].size() > 0) begin
               void'(exp_q[i].pop_front());
               void'(acc_q[i].pop_front());
            end
         end
         held[i] = out_valid[i] && !out_ready[i];
         if (in_valid[i] && in_ready[i]) begin
            exp_q[i].push_back(ref_calc(wof(i), in1[i] & mk(i), in2[i] & mk(i), cin[i], sub[i]));
            acc_q[i].push_back(cyc);
            acc_cnt[i]++;
         end
      end
   end

   task automatic chk(string name, logic [33:0] got, logic [33:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic send(int i, logic [31:0] a, logic [31:0] b, logic c, logic s);
      logic ok;
      ok = 1'b0;
      in1[i] = a; in2[i] = b; cin[i] = c; sub[i] = s; in_valid[i] = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         ok = in_ready[i];
         @(posedge clk); #1;
         if (ok) break;
      end
      in_valid[i] = 1'b0;
      if (!ok) begin
         checks++; failures++;
         $display("FAIL send_timeout inst%0d got=no_accept want=accept", i);
      end
   endtask

   task automatic wait_log(int i, int n);
      for (int t = 0; t < 200; t++) begin
         if (log_val[i].size() >= n) break;
         @(posedge clk); #1;
      end
      chk("log_count", 34'(log_val[i].size()), 34'(n));
   endtask

   task automatic clear_logs();
      for (int i = 0; i < N; i++) begin
         log_val[i].delete();
         log_lat[i].delete();
      end
   endtask

   logic [15:0] bp_want [6] = '{16'h1001, 16'h2001, 16'h3001, 16'h4001, 16'h5001, 16'h6001};
   bit          all_done;

   initial begin
      in_valid = '0; cin = '0; sub = '0; out_ready = '1;
      for (int i = 0; i < N; i++) begin
         in1[i] = '0; in2[i] = '0; acc_cnt[i] = 0; held[i] = 1'b0; last[i] = '0;
      end
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         chk("rst_flags_out", {ovf[i], cout[i], outv[i]}, 34'h0);
         chk("rst_out_valid", 34'(out_valid[i]), 34'h0);
         chk("rst_in_ready", 34'(in_ready[i]), 34'h1);
      end
      @(posedge clk); #1;

      // Back-to-back adds
      clear_logs();
      send(0, 32'h00FF, 32'h0001, 1'b0, 1'b0);
      send(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
      send(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0);
      wait_log(0, 3);
      if (log_val[0].size() >= 3) begin
         chk("add0", log_val[0][0], {1'b0, 1'b0, 32'h0100});
         chk("add1", log_val[0][1], {1'b0, 1'b1, 32'h0000});
         chk("add2", log_val[0][2], {1'b1, 1'b0, 32'h8000});
         chk("lat16_first", 34'(log_lat[0][0]), 34'd4);
         chk("lat16_third", 34'(log_lat[0][2]), 34'd4);
      end

      // Subtracts
      clear_logs();
      send(0, 32'h0005, 32'h0007, 1'b0, 1'b1);
      send(0, 32'h8000, 32'h0001, 1'b0, 1'b1);
      send(0, 32'h0010, 32'h0001, 1'b1, 1'b1);
      wait_log(0, 3);
      if (log_val[0].size() >= 3) begin
         chk("sub0", log_val[0][0], {1'b0, 1'b0, 32'hFFFE});
         chk("sub1", log_val[0][1], {1'b1, 1'b1, 32'h7FFF});
         chk("sub2", log_val[0][2], {1'b0, 1'b1, 32'h000E});
      end

      // Backpressure
      clear_logs();
      out_ready[0] = 1'b0;
      fork
         begin
            for (int k = 0; k < 6; k++) send(0, 32'(k + 1) << 12, 32'h0001, 1'b0, 1'b0);
         end
         begin
            for (int t = 0; t < 50; t++) begin
               @(negedge clk);
               if (out_valid[0]) break;
            end
            for (int h = 0; h < 5; h++) begin
               chk("bp_in_ready", 34'(in_ready[0]), 34'h0);
               chk("bp_out_valid", 34'(out_valid[0]), 34'h1);
               @(negedge clk);
            end
            @(posedge clk); #1;
            out_ready[0] = 1'b1;
         end
      join
      wait_log(0, 6);
      if (log_val[0].size() >= 6)
         for (int k = 0; k < 6; k++) chk("bp_order", log_val[0][k], {2'b00, 16'h0, bp_want[k]});

      // Bubbles
      clear_logs();
      send(0, 32'h1234, 32'h1111, 1'b0, 1'b0); @(posedge clk); #1;
      send(0, 32'h0F0F, 32'h00F1, 1'b0, 1'b0); @(posedge clk); #1;
      send(0, 32'hA000, 32'h6000, 1'b0, 1'b0); @(posedge clk); #1;
      send(0, 32'h4000, 32'h4000, 1'b0, 1'b0);
      wait_log(0, 4);
      if (log_val[0].size() >= 4) begin
         chk("bub0", log_val[0][0], {1'b0, 1'b0, 32'h2345});
         chk("bub1", log_val[0][1], {1'b0, 1'b0, 32'h1000});
         chk("bub2", log_val[0][2], {1'b0, 1'b1, 32'h0000});
         chk("bub3", log_val[0][3], {1'b1, 1'b0, 32'h8000});
         for (int k = 0; k < 4; k++) chk("bub_lat", 34'(log_lat[0][k]), 34'd4);
      end

      // Reset mid-flight
      clear_logs();
      send(0, 32'h0001, 32'h0002, 1'b0, 1'b0);
      send(0, 32'h0003, 32'h0004, 1'b0, 1'b0);
      in1[0] = 32'h0005; in2[0] = 32'h0006; in_valid[0] = 1'b1; rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid[0] = 1'b0;
      @(negedge clk);
      chk("midrst_valid", 34'(out_valid[0]), 34'h0);
      chk("midrst_out", {ovf[0], cout[0], outv[0]}, 34'h0);
      repeat (10) @(posedge clk);
      #1;
      chk("midrst_no_stale", 34'(log_val[0].size()), 34'd0);

      // Other geometries
      clear_logs();
      send(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      send(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      send(2, 32'h7F, 32'h01, 1'b0, 1'b0);
      send(2, 32'h05, 32'h07, 1'b0, 1'b1);
      wait_log(1, 2);
      wait_log(2, 2);
      if (log_val[1].size() >= 2 && log_val[2].size() >= 2) begin
         chk("w32_add0", log_val[1][0], {1'b0, 1'b1, 32'h0});
         chk("w32_add1", log_val[1][1], {1'b1, 1'b0, 32'h8000_0000});
         chk("w32_lat", 34'(log_lat[1][0]), 34'd4);
         chk("w8_add", log_val[2][0], {1'b1, 1'b0, 32'h80});
         chk("w8_sub", log_val[2][1], {1'b0, 1'b0, 32'hFE});
         chk("w8_lat", 34'(log_lat[2][0]), 34'd1);
      end

      // Random traffic with random stalls on all three instances
      for (int i = 0; i < N; i++) acc_cnt[i] = 0;
      for (int r = 0; r < 20000; r++) begin
         all_done = 1'b1;
         for (int i = 0; i < N; i++) begin
            if (acc_cnt[i] < 1000) begin
               all_done     = 1'b0;
               in_valid[i]  = ($urandom_range(0, 3) != 0);
               in1[i]       = $urandom & mk(i);
               in2[i]       = $urandom & mk(i);
               cin[i]       = 1'($urandom_range(0, 1));
               sub[i]       = 1'($urandom_range(0, 1));
            end else begin
               in_valid[i]  = 1'b0;
            end
            out_ready[i] = ($urandom_range(0, 9) < 7);
         end
         if (all_done) break;
         @(posedge clk); #1;
      end
      for (int i = 0; i < N; i++) chk("rand_accepted", 34'(acc_cnt[i] >= 1000), 34'h1);

      in_valid = '0;
      out_ready = '1;
      for (int t = 0; t < 100; t++) begin
         if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
         @(posedge clk); #1;
      end
      for (int i = 0; i < N; i++) chk("drain_empty", 34'(exp_q[i].size()), 34'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
